// File: rtl/bram_stream_reader.sv
// Streaming read initiator: reads `length` words from a registered-read BRAM
// and presents them on a valid/ready stream. Optional m_tlast via BRAM_STREAM_READER_LAST_EN.
module bram_stream_reader #(
  parameter int FIFO_SIZE = 1024,
  parameter int BIT_WIDTH = 1024,
  localparam int AW = $clog2(FIFO_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [AW-1:0]        length,
  output logic                 busy,
  output logic                 done,
  output logic                 bram_re,
  output logic [AW-1:0]        bram_raddr,
  input  logic [BIT_WIDTH-1:0] bram_dout,
  output logic [BIT_WIDTH-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready
`ifdef BRAM_STREAM_READER_LAST_EN
  ,
  output logic                 m_tlast
`endif
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        addr_q;
  logic [AW-1:0]        issue_q;
  logic [AW-1:0]        beat_q;
  logic [BIT_WIDTH-1:0] buf_q [2];
  logic                 rd_ptr_q, wr_ptr_q;
  logic [1:0]           occ_q;
  logic                 inflight_q;
  logic                 done_q;

  logic                 pop;
  logic                 issue;
  logic                 accept;
  logic                 last_pop;
  logic [2:0]           credit_use;

  // A same-cycle pop frees its slot, so the credit check subtracts it to avoid a bubble.
  always_comb begin
    pop        = (occ_q != 2'd0) && m_tready;
    credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == READ) && (issue_q != '0) && (credit_use < 3'd2);
    accept     = (state_q == IDLE) && start;
    last_pop   = (state_q == DRAIN) && pop && (beat_q == AW'(1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && (length != '0)) state_d = READ;
      READ:    if (issue && (issue_q == AW'(1))) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      beat_q     <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= last_pop || (accept && (length == '0));
      inflight_q <= issue;
      if (accept) begin
        addr_q  <= start_addr;
        issue_q <= length;
        beat_q  <= length;
      end else begin
        if (issue) begin
          addr_q  <= (addr_q == AW'(FIFO_SIZE - 1)) ? '0 : addr_q + AW'(1);
          issue_q <= issue_q - AW'(1);
        end
        if (pop) beat_q <= beat_q - AW'(1);
      end
      // Returning read data is always captured; the credit rule guarantees a free slot.
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= bram_dout;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign bram_re    = issue;
  assign bram_raddr = addr_q;
  assign m_tvalid   = (occ_q != 2'd0);
  assign m_tdata    = buf_q[rd_ptr_q];
`ifdef BRAM_STREAM_READER_LAST_EN
  assign m_tlast    = m_tvalid && (beat_q == AW'(1));
`endif

endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Streaming read initiator for the simple dual-port block RAM. On a start command it reads `length` consecutive words from the RAM read port, beginning at `start_addr`. Each word is presented on a valid/ready output stream with full backpressure support. It hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, sustaining one beat per cycle while `m_tready` stays high.

## Interface
- `FIFO_SIZE`, default 1024: RAM depth in words; address wraps at this value.
- `BIT_WIDTH`, default 1024: RAM word width and stream data width.
- `AW` (local): `$clog2(FIFO_SIZE)+1`, the RAM address port width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe; accepted only in IDLE.
- `start_addr`  in  AW  first read address; must be < FIFO_SIZE.
- `length`  in  AW  number of words to read (0..FIFO_SIZE).
- `busy`  out  1  high while a command is in progress.
- `done`  out  1  one-cycle pulse when a command completes.
- `bram_re`  out  1  RAM read enable.
- `bram_raddr`  out  AW  RAM read address.
- `bram_dout`  in  BIT_WIDTH  RAM read data, valid the cycle after `bram_re`.
- `m_tdata`  out  BIT_WIDTH  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  final beat marker; present only with `BRAM_STREAM_READER_LAST_EN`.

## Operation
- FSM states are IDLE, READ and DRAIN.
- **IDLE**
  - `start`=1 latches `start_addr` into the address register and `length` into the issue and beat counters.
  - Moves to READ if `length` != 0.
  - If `length` == 0, stays in IDLE, pulses `done` the next cycle and emits no beats.
- **READ**
  - `bram_re`=1 when issue count > 0 and (buffer occupancy + in-flight read − pop this cycle) < 2.
  - Each issue increments the address and decrements the issue count.
  - Address wraps from FIFO_SIZE−1 to 0.
  - Goes to DRAIN when the issue count reaches 0.
- **In-flight reads:** one read can be in flight. `bram_dout` is written into the buffer on the cycle after `bram_re`, unconditionally; the credit rule guarantees space.
- **DRAIN:** no reads are issued. Returns to IDLE on the handshake of the last beat, i.e. when the beat counter goes 1→0.
- **Output buffer:** 2-entry FIFO.
  - `m_tvalid` = occupancy != 0.
  - `m_tdata` = head entry.
  - Pop on `m_tvalid && m_tready`; each pop decrements the beat counter.
  - `m_tdata` must stay stable while `m_tvalid`=1 and `m_tready`=0.
- **Ignored inputs:** `start` outside IDLE is ignored. `start_addr`/`length` changes after acceptance have no effect.
- **busy/done:**
  - `busy`=1 from the cycle after acceptance through the last-beat handshake cycle.
  - `done`=1 for exactly the cycle after that handshake, with `busy`=0.
- **Reset** (any time, including mid-command):
  - FSM goes to IDLE; counters, occupancy and in-flight flag clear.
  - Reset values: `busy`=0, `done`=0, `bram_re`=0, `bram_raddr`=0, `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0.
  - Partially read data is discarded. A RAM read in flight at reset is not captured.

## Timing
- `start` sampled at cycle 0 → `bram_re`=1 with `bram_raddr`=`start_addr` in cycle 1 → data in `bram_dout` in cycle 2 → `m_tvalid`=1 in cycle 3.
- With `m_tready` held high, beats appear on consecutive cycles 3..3+length−1. `done` pulses in cycle 3+length.
- With `m_tready` low, at most 2 beats are buffered and `bram_re` stays low until a pop frees a credit. A pop in the same cycle counts as freeing a credit, so no bubble is added.
- Minimum spacing between commands: a new `start` is accepted in the `done` cycle.

## Configuration
- `BRAM_STREAM_READER_LAST_EN` defined:
  - `m_tlast` port exists.
  - `m_tlast`=1 exactly while the buffer head is the final beat of the command, i.e. beat counter == 1 and `m_tvalid`=1.
  - `m_tlast` is 0 otherwise and after reset.
- Not defined: the `m_tlast` port and its logic are absent; all other behaviour is identical.

## Test plan
- RAM preloaded mem[i]=i; `start_addr`=5, `length`=4, `m_tready`=1 → `m_tdata` 5,6,7,8 in cycles 3–6; `m_tlast` on 8; `done` in cycle 7.
- `start_addr`=FIFO_SIZE−2, `length`=4 → data from addresses FIFO_SIZE−2, FIFO_SIZE−1, 0, 1 (wrap).
- `length`=8, `m_tready` toggled 1,0,0,1,… randomly → all 8 beats in order, none lost or duplicated; `m_tdata` stable while stalled; never more than 2 outstanding.
- `length`=0 → no `bram_re`, no `m_tvalid`, `done` pulse the cycle after `start`; second `start` during a busy command → ignored, output unchanged.
- `rst` asserted mid-command after 2 of 6 beats → all outputs zero immediately. A new command after release streams correctly from its own `start_addr`.
